// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port indices for mem_arbiter.
package mem_arb_pkg;

  // Sequencer state, 2-bit encoding kept as plain constants
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Requester indices
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Index of the port that is not idx
  function automatic logic other_port(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way picker. When both ports request, the
// port named by pref wins; a single requester always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic pref,
  output logic gnt_valid,
  output logic gnt_idx
);

  // Select the winning port from the current requests and preference
  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) begin
      gnt_idx = pref;
    end else if (req1) begin
      gnt_idx = PORT_DBG;
    end else begin
      gnt_idx = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port registered-output memory between the
// cpu (port 0) and a debug/loader master (port 1). Accesses are serialised
// through IDLE -> ACCESS -> RESP, ending in a one-cycle ack on the winner.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration); when
// undefined, port 0 has fixed priority and no pointer is built.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  state_t                r_state;
  logic                  r_gnt;
  logic                  r_is_write;
  logic                  r_busy;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_pref;
  logic                  w_gnt_valid;
  logic                  w_gnt_idx;
  logic                  w_grant;

  // A grant only happens from IDLE; requests elsewhere are ignored
  assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;

  arb_pick u_arb_pick (
    .req0      (req0),
    .req1      (req1),
    .pref      (w_pref),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

`ifdef MEM_ARB_RR_EN
  logic r_ptr;

  // Round-robin pointer: after every grant prefer the port that lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PORT_CPU;
    end else if (w_grant) begin
      r_ptr <= other_port(w_gnt_idx);
    end
  end

  assign w_pref = r_ptr;
`else
  assign w_pref = PORT_CPU;
`endif

  // Sequencer: latch the winner's access, drive memory, then ack and capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= PORT_CPU;
      r_is_write <= 1'b0;
      r_busy     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= {ADDR_WIDTH{1'b0}};
      r_mem_data <= {DATA_WIDTH{1'b0}};
      r_rdata    <= {DATA_WIDTH{1'b0}};
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt      <= w_gnt_idx;
            r_is_write <= (w_gnt_idx == PORT_DBG) ? we1 : we0;
            r_mem_we   <= (w_gnt_idx == PORT_DBG) ? we1 : we0;
            r_mem_addr <= (w_gnt_idx == PORT_DBG) ? addr1 : addr0;
            r_mem_data <= (w_gnt_idx == PORT_DBG) ? wdata1 : wdata0;
            r_busy     <= 1'b1;
            r_state    <= ST_ACCESS;
          end else begin
            r_mem_we <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // Memory samples address/data/we at this edge
          r_mem_we <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          r_ack0 <= (r_gnt == PORT_CPU);
          r_ack1 <= (r_gnt == PORT_DBG);
          if (!r_is_write) begin
            r_rdata <= mem_out;
          end
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a
// registered-output memory model and a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, mem_we;
  logic [DW-1:0] rdata, mem_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_out;

  // Memory model with a backdoor write port for preloading
  logic [DW-1:0] mem [0:63];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  // Reference model state
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] ref_rdata;
  int            ref_ptr;
  logic          op_we   [0:1];
  logic [AW-1:0] op_addr [0:1];
  logic [DW-1:0] op_data [0:1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    else if (bd_we) mem[bd_addr] <= bd_data;
    mem_out <= mem[mem_addr];
  end

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_out(mem_out)
  );

  // Winner by the arbitration rules
  function automatic int exp_winner(input bit r0, input bit r1);
    if (r0 && r1) return RR_EN ? ref_ptr : 0;
    if (r1) return 1;
    return 0;
  endfunction

  // Apply a completed access to the model; returns the expected rdata
  function automatic logic [DW-1:0] model_complete(input int p);
    if (op_we[p]) ref_mem[op_addr[p]] = op_data[p];
    else ref_rdata = ref_mem[op_addr[p]];
    ref_ptr = 1 - p;
    return ref_rdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_we[p] = we; op_addr[p] = a; op_data[p] = d;
    if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; end
    else begin we1 = we; addr1 = a; wdata1 = d; end
  endtask

  // Bounded wait for the next ack; port=-1 on timeout, 2 if both fire
  task automatic wait_ack(output int port, output int cyc);
    port = -1; cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ack0 || ack1) begin
        port = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    set_op(0, 1'b0, 6'd0, 16'h0000);
    set_op(1, 1'b0, 6'd0, 16'h0000);
    #2;
    for (int i = 0; i < 64; i++) begin
      v = (i == 5) ? 16'h00AB : DW'($urandom);
      bd_we = 1'b1; bd_addr = AW'(i); bd_data = v; ref_mem[i] = v;
      tick();
    end
    bd_we = 1'b0;
    checks++;
    if ({ack0, ack1, busy, mem_we, mem_addr, mem_data, rdata} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {ack0, ack1, busy, mem_we, mem_addr, mem_data, rdata});
    end
    rst_n = 1'b1; ref_ptr = 0; ref_rdata = 16'h0000;
    tick();
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ack0=%b ack1=%b expected 0", busy, ack0, ack1);
    end
  endtask

  task automatic test_read_p0();
    logic [DW-1:0] exp;
    set_op(0, 1'b0, 6'd5, DW'($urandom));
    req0 = 1'b1;
    tick();
    checks++;
    if (mem_addr !== 6'd5 || busy !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL p0_access: addr=%0d busy=%b we=%b expected 5 1 0", mem_addr, busy, mem_we);
    end
    tick();
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL p0_resp: ack0=%b busy=%b expected 0 1", ack0, busy);
    end
    tick();
    exp = model_complete(0);
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL p0_ack: ack0=%b ack1=%b busy=%b expected 1 0 0", ack0, ack1, busy);
    end
    checks++;
    if (rdata !== exp || rdata !== 16'h00AB) begin
      errors++;
      $display("FAIL p0_rdata: got %h expected %h", rdata, exp);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++;
      $display("FAIL p0_ack_pulse: ack0=%b ack1=%b expected 0 0", ack0, ack1);
    end
  endtask

  task automatic test_write_read_p1();
    int we_cnt = 0, n = 0, first = 0, second = 0;
    logic [DW-1:0] exp;
    set_op(1, 1'b1, 6'd63, 16'h1234);
    req1 = 1'b1;
    for (int c = 1; c <= 12 && n < 2; c++) begin
      tick();
      if (mem_we) we_cnt++;
      checks++;
      if (ack0 !== 1'b0) begin
        errors++;
        $display("FAIL p1_no_ack0: ack0=%b expected 0", ack0);
      end
      if (ack1) begin
        exp = model_complete(1);
        checks++;
        if (rdata !== exp) begin
          errors++;
          $display("FAIL p1_rdata_%0d: got %h expected %h", n, rdata, exp);
        end
        if (n == 0) begin
          first = c;
          set_op(1, 1'b0, 6'd63, 16'h0000);
        end else begin
          second = c;
          req1 = 1'b0;
        end
        n++;
      end
    end
    req1 = 1'b0;
    checks++;
    if (we_cnt != 1) begin
      errors++;
      $display("FAIL p1_we_cycles: got %0d expected 1", we_cnt);
    end
    checks++;
    if (first != 3 || second - first != 3 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL p1_spacing: first=%0d gap=%0d rdata=%h expected 3 3 1234", first, second - first, rdata);
    end
  endtask

  task automatic test_arbitration();
    int p, c, w;
    logic [DW-1:0] exp;
    for (int k = 0; k < 2; k++) set_op(k, 1'($urandom), AW'($urandom), DW'($urandom));
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      w = exp_winner(1'b1, 1'b1);
      wait_ack(p, c);
      exp = model_complete(w);
      checks++;
      if (p != w || c != 3) begin
        errors++;
        $display("FAIL arb_order_%0d: port=%0d cycles=%0d expected port=%0d cycles=3", t, p, c, w);
      end
      checks++;
      if (rdata !== exp) begin
        errors++;
        $display("FAIL arb_rdata_%0d: got %h expected %h", t, rdata, exp);
      end
      set_op(w, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int p, c;
    logic [DW-1:0] exp;
    set_op(0, 1'b1, 6'd10, ~ref_mem[10]);
    req0 = 1'b1;
    tick();
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_we: got %b expected 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack0, ack1, busy, mem_we, mem_addr, mem_data, rdata} !== 42'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0", {ack0, ack1, busy, mem_we, mem_addr, mem_data, rdata});
    end
    req0 = 1'b0; ref_ptr = 0; ref_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_ack: ack0=%b ack1=%b expected 0 0", ack0, ack1);
      end
    end
    rst_n = 1'b1;
    set_op(1, 1'b0, 6'd10, 16'h0000);
    req1 = 1'b1;
    wait_ack(p, c);
    exp = model_complete(1);
    req1 = 1'b0;
    checks++;
    if (p != 1 || c != 3 || rdata !== exp) begin
      errors++;
      $display("FAIL post_reset_read: port=%0d cycles=%0d rdata=%h expected 1 3 %h", p, c, rdata, exp);
    end
  endtask

  task automatic test_ignore_busy();
    logic [DW-1:0] exp;
    set_op(0, 1'b0, AW'($urandom), 16'h0000);
    set_op(1, 1'b0, AW'($urandom), 16'h0000);
    req0 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (ack0 !== ((c % 3) == 0) || ack1 !== 1'b0) begin
        errors++;
        $display("FAIL ignore_ack_c%0d: ack0=%b ack1=%b expected %b 0", c, ack0, ack1, (c % 3) == 0);
      end
      if ((c % 3) == 0) begin
        exp = model_complete(exp_winner(1'b1, 1'b0));
        checks++;
        if (rdata !== exp) begin
          errors++;
          $display("FAIL ignore_rdata_c%0d: got %h expected %h", c, rdata, exp);
        end
        set_op(0, 1'b0, AW'($urandom), 16'h0000);
      end
      req1 = (c == 2);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_random_mix();
    int p, c, w, pat;
    logic [DW-1:0] exp;
    for (int r = 0; r < 10; r++) begin
      pat = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) set_op(k, 1'($urandom), AW'($urandom), DW'($urandom));
      req0 = pat[0]; req1 = pat[1];
      for (int k = 0; k < 2 && (req0 || req1); k++) begin
        w = exp_winner(req0, req1);
        wait_ack(p, c);
        exp = model_complete(w);
        checks++;
        if (p != w || c != 3 || rdata !== exp) begin
          errors++;
          $display("FAIL mix_r%0d_k%0d: port=%0d cycles=%0d rdata=%h expected %0d 3 %h", r, k, p, c, rdata, w, exp);
        end
        if (w == 0) req0 = 1'b0;
        else req1 = 1'b0;
      end
    end
    tick();
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = 6'd0; bd_data = 16'h0000;
    test_reset();
    test_read_p0();
    test_write_read_p1();
    test_arbitration();
    test_reset_mid();
    test_ignore_busy();
    test_random_mix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port program/data `memory` between the `cpu` (port 0) and a debug/loader master (port 1, e.g. switch/button memory inspector or keyboard loader). The arbiter sits between both masters and the memory instance on the `slow_clk` domain. It serialises accesses through a three-state sequencer and returns read data with a per-port acknowledge pulse.

## Interface
- `ADDR_WIDTH`, 6: memory address width.
- `DATA_WIDTH`, 16: memory word width.

- `clk`  in  1  arbiter/memory clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1 each  access request; held high until the matching ack.
- `we0`, `we1`  in  1 each  1 = write, 0 = read; stable while req high.
- `addr0`, `addr1`  in  ADDR_WIDTH each  word address; stable while req high.
- `wdata0`, `wdata1`  in  DATA_WIDTH each  write data; stable while req high.
- `ack0`, `ack1`  out  1 each  one-cycle completion pulse.
- `rdata`  out  DATA_WIDTH  read data, valid in the ack cycle of a read, held afterwards.
- `busy`  out  1  high in ACCESS and RESP.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_data`  out  DATA_WIDTH  memory write data.
- `mem_out`  in  DATA_WIDTH  memory read data, registered inside memory, valid one cycle after address sampling.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE, `mem_we`=0.
- IDLE, any request: pick a winner, latch its `we`/`addr`/`wdata` into `mem_we`/`mem_addr`/`mem_data`, go to ACCESS.
- ACCESS: memory samples the latched signals at the end of the cycle. Go to RESP. `mem_we` is forced to 0 on exit.
- RESP: pulse the winner's ack. On a read, load `rdata` from `mem_out`. On a write, `rdata` holds its previous value. Go to IDLE.
- `mem_addr` and `mem_data` hold their last values outside ACCESS.
- `mem_we` is 1 only during ACCESS of a write.
- Requests are ignored while not in IDLE. A req deasserted before its ack is a protocol violation: the latched access still completes and the ack still fires.
- Winner selection is described under Configuration.
- Reset, asynchronous and usable at any point including mid-transaction: state=IDLE, all outputs 0 (`ack0`, `ack1`, `busy`, `mem_we`, `mem_addr`, `mem_data`, `rdata`), round-robin pointer = port 0 preferred. An in-flight access is dropped with no ack.

## Timing
- Request seen in IDLE at edge N: ACCESS during cycle N..N+1, RESP during N+1..N+2, ack high for exactly one cycle after edge N+2.
- Latency is 2 cycles from the granting edge to the ack. Maximum throughput is one access per 3 cycles.
- A requester that holds req after its ack is re-arbitrated at the first IDLE edge. Back-to-back accesses from one port are therefore 3 cycles apart.
- `ack0` and `ack1` are never high in the same cycle.
- `busy` = (state != IDLE), registered.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A one-bit pointer names the preferred port.
  - Both requesting: the preferred port wins.
  - After any grant, the pointer moves to the other port.
  - A single requester always wins.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 (cpu) always wins when requesting, and the pointer logic is not built. Port 1 can starve. This is acceptable only because the cpu leaves idle cycles.

## Structure
- Package `mem_arb_pkg` holds:
  - the state typedef (IDLE/ACCESS/RESP, 2-bit encoding);
  - port index constants `PORT_CPU`=0 and `PORT_DBG`=1.
- Sub-module `arb_pick`: combinational two-way picker.
  - Inputs: `req0`, `req1`, `pref`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - `pref` is tied to 0 when `MEM_ARB_RR_EN` is undefined.
- The FSM, request latches, pointer and `rdata` register live in `mem_arbiter`.

## Test plan
- Reset, then port 0 reads addr 5 holding 16'h00AB: `mem_addr`=5 during ACCESS, `ack0` pulses 2 cycles after grant, `rdata`=16'h00AB; `ack1` stays 0.
- Port 1 writes 16'h1234 to addr 63, then reads addr 63: `mem_we`=1 for exactly one cycle; the read returns 16'h1234; the accesses are 3 cycles apart.
- Both ports hold req for 6 transactions with `MEM_ARB_RR_EN`: grant order 0,1,0,1,0,1.
  - Without the macro: six acks, all on port 0; `ack1` stays 0.
- Assert `rst_n`=0 during ACCESS of a write: all outputs go to 0 immediately, no ack.
  - After release with port 1 requesting: normal ack 2 cycles after grant.
- Port 0 holds req continuously while port 1 pulses req for one cycle during RESP: port 1's request is ignored; `ack0` follows every 3 cycles.
